tx_frame_scheduler: RTL and testbench

// Round-robin scheduler sharing the single TX_Ethernet frame buffer among NUM_REQ payload sources.

---
 rtl/tx_sched_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/tx_frame_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_tx_frame_scheduler.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_sched_pkg.sv
// Shared types for the TX frame scheduler: FSM state encoding and fixed TX mode.
package tx_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CLOSE,
    START,
    WAIT_END,
    ABORT,
    IFG
  } state_e;

  localparam logic [1:0] TX_MODE_NORMAL = 2'b01;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      idx_o,
  output logic               valid_o
);

  always_comb begin
    int cand;
    cand    = 0;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr_i) + k) % NUM_REQ;
      if (!valid_o && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        idx_o         = IW'(cand);
        valid_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Round-robin owner of the TX_Ethernet frame buffer: copies one source's payload
// through the count_addr toggle handshake, starts a normal-mode send, waits for it to end.
module tx_frame_scheduler
  import tx_sched_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 4095,
  parameter int IFG_CYCLES    = 96
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*4-1:0] req_len,
  output logic [NUM_REQ-1:0]   grant,
  output logic [3:0]           src_rd_addr,
  input  logic [7:0]           src_rd_data,
  output logic                 done,
  output logic                 err,
  output logic [7:0]           tx_data,
  output logic                 tx_count_addr,
  output logic                 tx_receive_tx,
  output logic                 tx_receive_mac,
  output logic [1:0]           tx_mode,
  input  logic                 tx_busy
);

  localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW  = $clog2(START_TIMEOUT + 1);
  localparam int IFW = $clog2(IFG_CYCLES + 1);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [3:0]           len_q, len_d;
  logic [3:0]           byte_cnt_q, byte_cnt_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 cnt_addr_q, cnt_addr_d;
  logic                 rx_tx_q, rx_tx_d;
  logic                 rx_mac_q, rx_mac_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [IFW-1:0]       ifg_q, ifg_d;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IW-1:0]        arb_idx;
  logic                 arb_valid;
  logic [3:0]           len_arr [NUM_REQ];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_len
    assign len_arr[gi] = req_len[4*gi +: 4];
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    tx_data_d  = tx_data_q;
    cnt_addr_d = cnt_addr_q;
    rx_tx_d    = rx_tx_q;
    rx_mac_d   = rx_mac_q;
    timer_d    = timer_q;
    ifg_d      = ifg_q;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d    = arb_grant;
          len_d      = len_arr[arb_idx];
          byte_cnt_d = 4'd0;
          rr_ptr_d   = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + IW'(1);
          if (len_arr[arb_idx] == 4'd0) begin
            state_d = ABORT;
          end else begin
            rx_tx_d = 1'b1;
            state_d = LOAD_A;
          end
        end
      end
      // src_rd_addr is presented here; the source answers during LOAD_B.
      LOAD_A: state_d = LOAD_B;
      LOAD_B: begin
        tx_data_d  = src_rd_data;
        cnt_addr_d = ~cnt_addr_q;
        if (byte_cnt_q == len_q - 4'd1) begin
          state_d = CLOSE;
        end else begin
          byte_cnt_d = byte_cnt_q + 4'd1;
          state_d    = LOAD_A;
        end
      end
      CLOSE: begin
        rx_tx_d    = 1'b0;
        cnt_addr_d = 1'b0;
        rx_mac_d   = 1'b1;
        timer_d    = '0;
        state_d    = START;
      end
      START: begin
        if (tx_busy) begin
          rx_mac_d = 1'b0;
          state_d  = WAIT_END;
        end else if (timer_q == TW'(START_TIMEOUT - 1)) begin
          rx_mac_d = 1'b0;
          done_d   = 1'b1;
          err_d    = 1'b1;
          ifg_d    = '0;
          state_d  = IFG;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_END: begin
        if (!tx_busy) begin
          done_d  = 1'b1;
          ifg_d   = '0;
          state_d = IFG;
        end
      end
      ABORT: begin
        done_d  = 1'b1;
        err_d   = 1'b1;
        ifg_d   = '0;
        state_d = IFG;
      end
      // Grant survives the first IFG cycle so it still qualifies the done pulse.
      IFG: begin
        grant_d = '0;
        if (ifg_q == IFW'(IFG_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          ifg_d = ifg_q + IFW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      len_q      <= 4'd0;
      byte_cnt_q <= 4'd0;
      rr_ptr_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tx_data_q  <= 8'h00;
      cnt_addr_q <= 1'b0;
      rx_tx_q    <= 1'b0;
      rx_mac_q   <= 1'b0;
      timer_q    <= '0;
      ifg_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tx_data_q  <= tx_data_d;
      cnt_addr_q <= cnt_addr_d;
      rx_tx_q    <= rx_tx_d;
      rx_mac_q   <= rx_mac_d;
      timer_q    <= timer_d;
      ifg_q      <= ifg_d;
    end
  end

  assign grant          = grant_q;
  assign src_rd_addr    = byte_cnt_q;
  assign done           = done_q;
  assign err            = err_q;
  assign tx_data        = tx_data_q;
  assign tx_count_addr  = cnt_addr_q;
  assign tx_receive_tx  = rx_tx_q;
  assign tx_receive_mac = rx_mac_q;
  assign tx_mode        = TX_MODE_NORMAL;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler with a registered-read payload source model.
module tb_tx_frame_scheduler;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [4*N-1:0] req_len;
  logic [N-1:0]   grant;
  logic [3:0]     src_rd_addr;
  logic [7:0]     src_rd_data;
  logic           done, err;
  logic [7:0]     tx_data;
  logic           tx_count_addr, tx_receive_tx, tx_receive_mac;
  logic [1:0]     tx_mode;
  logic           tx_busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] src_mem [N][16];

  always #5 clk = ~clk;

  tx_frame_scheduler #(
    .NUM_REQ       (N),
    .START_TIMEOUT (4095),
    .IFG_CYCLES    (96)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_len        (req_len),
    .grant          (grant),
    .src_rd_addr    (src_rd_addr),
    .src_rd_data    (src_rd_data),
    .done           (done),
    .err            (err),
    .tx_data        (tx_data),
    .tx_count_addr  (tx_count_addr),
    .tx_receive_tx  (tx_receive_tx),
    .tx_receive_mac (tx_receive_mac),
    .tx_mode        (tx_mode),
    .tx_busy        (tx_busy)
  );

  // Payload source: one clk read latency, addressed by the granted source.
  always @(posedge clk) begin
    logic [7:0] d;
    d = 8'h00;
    for (int i = 0; i < N; i++) if (grant[i]) d = src_mem[i][src_rd_addr];
    src_rd_data <= d;
  end

  task automatic do_reset();
    reset   = 1'b1;
    req     = '0;
    req_len = '0;
    tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    req     = '0;
    req_len = '0;
    tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({grant, src_rd_addr, done, err, tx_data, tx_count_addr, tx_receive_tx, tx_receive_mac} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got grant=%b addr=%h done=%b err=%b data=%h ca=%b rtx=%b mac=%b want all 0",
               grant, src_rd_addr, done, err, tx_data, tx_count_addr, tx_receive_tx, tx_receive_mac);
    end
    total++;
    if (tx_mode !== 2'b01) begin
      bad++;
      $display("FAIL reset_mode: got %b want 01", tx_mode);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({grant, done, tx_receive_tx, tx_receive_mac} !== '0) begin
      bad++;
      $display("FAIL idle_no_req: got grant=%b done=%b rtx=%b mac=%b want 0", grant, done, tx_receive_tx, tx_receive_mac);
    end
    total++;
    if (tx_mode !== 2'b01) begin
      bad++;
      $display("FAIL idle_mode: got %b want 01", tx_mode);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_frame();
    logic [7:0] got [3];
    int   ntog, last_tog, mac_cnt, hold, drop_cyc;
    bit   gap_ok, gseen, dseen, busy_done;
    logic prev_ca, prev_rtx;
    do_reset();
    ntog = 0; last_tog = 0; mac_cnt = 0; hold = 0; drop_cyc = -10;
    gap_ok = 1; gseen = 0; dseen = 0; busy_done = 0;
    for (int i = 0; i < 3; i++) got[i] = 8'h00;
    src_mem[1][0] = 8'hAA; src_mem[1][1] = 8'hBB; src_mem[1][2] = 8'hCC;
    req_len  = 16'h0030;
    prev_ca  = tx_count_addr;
    prev_rtx = tx_receive_tx;
    req      = 4'b0010;
    for (int cyc = 0; cyc < 300 && !dseen; cyc++) begin
      @(negedge clk);
      if (!gseen && grant !== 4'b0000) begin
        gseen = 1;
        total++;
        if (grant !== 4'b0010) begin
          bad++;
          $display("FAIL single_grant: got %b want 0010", grant);
        end
      end
      if (tx_receive_tx && tx_count_addr !== prev_ca) begin
        if (ntog < 3) got[ntog] = tx_data;
        if (ntog > 0 && cyc - last_tog != 2) gap_ok = 0;
        ntog++;
        last_tog = cyc;
      end
      if (prev_rtx && !tx_receive_tx) begin
        total++;
        if (tx_count_addr !== 1'b0) begin
          bad++;
          $display("FAIL single_close_ca: got %b want 0", tx_count_addr);
        end
      end
      prev_ca  = tx_count_addr;
      prev_rtx = tx_receive_tx;
      if (tx_receive_mac) mac_cnt++;
      if (tx_busy) begin
        hold++;
        if (hold == 10) begin
          tx_busy = 1'b0; drop_cyc = cyc; busy_done = 1;
        end
      end else if (tx_receive_mac && !busy_done && mac_cnt == 3) begin
        tx_busy = 1'b1; hold = 0;
      end
      if (done) begin
        dseen = 1;
        total++;
        if (err !== 1'b0 || grant !== 4'b0010 || cyc != drop_cyc + 1) begin
          bad++;
          $display("FAIL single_done: got err=%b grant=%b at cyc %0d want err=0 grant=0010 at cyc %0d",
                   err, grant, cyc, drop_cyc + 1);
        end
        req = '0;
      end
    end
    total++;
    if (!dseen) begin bad++; $display("FAIL single_timeout: got no done want done"); end
    total++;
    if (ntog != 3) begin bad++; $display("FAIL single_toggles: got %0d want 3", ntog); end
    total++;
    if ({got[0], got[1], got[2]} !== 24'hAABBCC) begin
      bad++;
      $display("FAIL single_data: got %h %h %h want AA BB CC", got[0], got[1], got[2]);
    end
    total++;
    if (!gap_ok) begin bad++; $display("FAIL single_spacing: got toggle gap not 2 want 2"); end
    total++;
    if (mac_cnt != 3) begin bad++; $display("FAIL single_mac: got %0d mac-high clk want 3", mac_cnt); end
    $display("test_single_frame done");
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_order [5];
    int   n, zero_run, hold;
    logic [N-1:0] prev_g;
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
    do_reset();
    n = 0; zero_run = 0; hold = 0; prev_g = '0;
    req_len = 16'h1111;
    req     = 4'b1111;
    for (int cyc = 0; cyc < 3000 && n < 5; cyc++) begin
      @(negedge clk);
      if (grant !== 4'b0000 && prev_g === 4'b0000) begin
        total++;
        if (grant !== exp_order[n]) begin
          bad++;
          $display("FAIL rr_order[%0d]: got %b want %b", n, grant, exp_order[n]);
        end
        if (n > 0) begin
          total++;
          if (zero_run < 96) begin
            bad++;
            $display("FAIL rr_gap[%0d]: got %0d idle clk want >=96", n, zero_run);
          end
        end
        n++;
      end
      if (grant === 4'b0000) zero_run++; else zero_run = 0;
      prev_g = grant;
      if (tx_busy) begin
        hold++;
        if (hold == 2) tx_busy = 1'b0;
      end else if (tx_receive_mac) begin
        tx_busy = 1'b1; hold = 0;
      end
    end
    total++;
    if (n != 5) begin bad++; $display("FAIL rr_timeout: got %0d grants want 5", n); end
    $display("test_round_robin done");
  endtask

  task automatic test_len_zero();
    int gcyc;
    bit gseen, dseen, activity;
    logic prev_ca;
    do_reset();
    gcyc = 0; gseen = 0; dseen = 0; activity = 0;
    prev_ca = tx_count_addr;
    req_len = 16'h0000;
    req     = 4'b0100;
    for (int cyc = 0; cyc < 150; cyc++) begin
      @(negedge clk);
      if (tx_count_addr !== prev_ca || tx_receive_mac || tx_receive_tx) activity = 1;
      prev_ca = tx_count_addr;
      if (!gseen && grant !== 4'b0000) begin
        gseen = 1; gcyc = cyc;
        total++;
        if (grant !== 4'b0100 || done !== 1'b0) begin
          bad++;
          $display("FAIL len0_grant: got grant=%b done=%b want grant=0100 done=0", grant, done);
        end
      end else if (gseen && cyc == gcyc + 1) begin
        total++;
        if (done !== 1'b1 || err !== 1'b1 || grant !== 4'b0100) begin
          bad++;
          $display("FAIL len0_abort: got done=%b err=%b grant=%b want 1 1 0100", done, err, grant);
        end
        if (done === 1'b1) dseen = 1;
        req = '0;
      end
    end
    total++;
    if (!dseen) begin bad++; $display("FAIL len0_timeout: got no abort done want done"); end
    total++;
    if (activity) begin bad++; $display("FAIL len0_activity: got tx activity want none"); end
    $display("test_len_zero done");
  endtask

  task automatic test_start_timeout();
    int  mac_cnt, zero_run;
    bit  dseen, nseen;
    do_reset();
    mac_cnt = 0; zero_run = 0; dseen = 0; nseen = 0;
    src_mem[0][0] = 8'h11; src_mem[0][1] = 8'h22;
    req_len = 16'h0002;
    req     = 4'b0001;
    for (int cyc = 0; cyc < 9000 && !nseen; cyc++) begin
      @(negedge clk);
      if (!dseen) begin
        if (tx_receive_mac) mac_cnt++;
        if (done) begin
          dseen = 1;
          total++;
          if (mac_cnt != 4095 || err !== 1'b1 || tx_receive_mac !== 1'b0) begin
            bad++;
            $display("FAIL timeout_done: got mac_clk=%0d err=%b mac=%b want 4095 1 0", mac_cnt, err, tx_receive_mac);
          end
        end
      end else begin
        if (grant === 4'b0000) zero_run++;
        else if (zero_run > 0) begin
          nseen = 1;
          total++;
          if (zero_run < 96 || grant !== 4'b0001) begin
            bad++;
            $display("FAIL timeout_regrant: got gap=%0d grant=%b want gap>=96 grant=0001", zero_run, grant);
          end
        end
      end
    end
    total++;
    if (!nseen) begin bad++; $display("FAIL timeout_bound: got done=%b regrant=%b want both", dseen, nseen); end
    $display("test_start_timeout done");
  endtask

  task automatic test_reset_midframe();
    int   gcyc, ntog;
    bit   gseen, fired, ok2, tseen;
    logic prev_ca;
    do_reset();
    gcyc = 0; ntog = 0; gseen = 0; fired = 0; tseen = 0;
    for (int i = 0; i < 10; i++) src_mem[0][i] = 8'h10 + 8'(i);
    req_len = 16'h000A;
    prev_ca = tx_count_addr;
    req     = 4'b0001;
    for (int cyc = 0; cyc < 200 && !fired; cyc++) begin
      @(negedge clk);
      if (tx_receive_tx && tx_count_addr !== prev_ca) ntog++;
      prev_ca = tx_count_addr;
      if (!gseen && grant !== 4'b0000) begin gseen = 1; gcyc = cyc; end
      if (gseen && cyc == gcyc + 11) begin
        total++;
        if (src_rd_addr !== 4'd5) begin
          bad++;
          $display("FAIL mid_addr: got %0d want 5", src_rd_addr);
        end
        reset = 1'b1;
        fired = 1;
      end
    end
    @(negedge clk);
    total++;
    if ({grant, src_rd_addr, done, err, tx_data, tx_count_addr, tx_receive_tx, tx_receive_mac} !== '0
        || tx_mode !== 2'b01) begin
      bad++;
      $display("FAIL mid_reset_outputs: got grant=%b addr=%h done=%b err=%b data=%h ca=%b rtx=%b mac=%b mode=%b want 0s mode 01",
               grant, src_rd_addr, done, err, tx_data, tx_count_addr, tx_receive_tx, tx_receive_mac, tx_mode);
    end
    total++;
    if (ntog != 5 || !fired) begin bad++; $display("FAIL mid_toggles: got %0d want 5", ntog); end
    reset = 1'b0;
    ok2 = 0;
    prev_ca = tx_count_addr;
    for (int cyc = 0; cyc < 50 && !tseen; cyc++) begin
      @(negedge clk);
      if (!ok2 && grant !== 4'b0000) begin
        ok2 = 1;
        total++;
        if (src_rd_addr !== 4'd0 || grant !== 4'b0001) begin
          bad++;
          $display("FAIL mid_restart: got addr=%0d grant=%b want 0 0001", src_rd_addr, grant);
        end
      end
      if (tx_receive_tx && tx_count_addr !== prev_ca) begin
        tseen = 1;
        total++;
        if (tx_data !== 8'h10) begin
          bad++;
          $display("FAIL mid_first_byte: got %h want 10", tx_data);
        end
      end
      prev_ca = tx_count_addr;
    end
    total++;
    if (!tseen) begin bad++; $display("FAIL mid_restart_timeout: got no toggle want toggle"); end
    $display("test_reset_midframe done");
  endtask

  task automatic test_busy_long();
    int  bcnt, drop_cyc, done_cyc;
    bit  started, dseen, grant_leak, finished;
    do_reset();
    bcnt = 0; drop_cyc = -10; done_cyc = 0;
    started = 0; dseen = 0; grant_leak = 0; finished = 0;
    src_mem[3][0] = 8'h5A;
    req_len = 16'h1000;
    req     = 4'b1000;
    for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
      @(negedge clk);
      if (dseen) begin
        if (grant !== 4'b0000) grant_leak = 1;
        if (cyc == done_cyc + 94) finished = 1;
      end else if (done) begin
        dseen = 1; done_cyc = cyc;
        total++;
        if (cyc != drop_cyc + 1 || err !== 1'b0 || grant !== 4'b1000) begin
          bad++;
          $display("FAIL busy_done: got cyc=%0d err=%b grant=%b want cyc=%0d err=0 grant=1000",
                   cyc, err, grant, drop_cyc + 1);
        end
        req = '0;
      end
      if (tx_busy) begin
        bcnt++;
        if (bcnt == 200) begin
          total++;
          if (done !== 1'b0) begin bad++; $display("FAIL busy_early_done: got 1 want 0"); end
          tx_busy = 1'b0; drop_cyc = cyc;
        end
      end else if (tx_receive_mac && !started) begin
        tx_busy = 1'b1; started = 1; bcnt = 0;
      end
    end
    total++;
    if (!finished) begin bad++; $display("FAIL busy_timeout: got done=%b want done and IFG", dseen); end
    total++;
    if (grant_leak) begin bad++; $display("FAIL busy_ifg_grant: got nonzero want 0000"); end
    $display("test_busy_long done");
  endtask

  initial begin
    reset   = 1'b1;
    req     = '0;
    req_len = '0;
    tx_busy = 1'b0;
    for (int s = 0; s < N; s++)
      for (int b = 0; b < 16; b++) src_mem[s][b] = 8'h00;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_len_zero();
    test_start_timeout();
    test_reset_midframe();
    test_busy_long();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
